// File: rtl/clkdiv_multi.sv
// clkdiv_multi: NCH-channel programmable clock divider.
//
// Each channel turns inclk into a square wave whose period is its divisor,
// measured in inclk cycles. It is high for (div+1)>>1 cycles and low for
// the rest. A one-cycle tick marks each rising edge of the channel clock.
// A divisor written while a channel is live is held as pending. It is applied
// only at a period boundary, so no runt or stretched period is ever produced.
//
// Ports
//   inclk      in   sole clock, rising edge
//   reset      in   synchronous, active-high
//   enable     in   [NCH]    per-channel run enable
//   sync       in   1-cycle pulse, restarts all running channels at phase 0
//   cfg_valid  in   divisor write request
//   cfg_ch     in   [CHW]    target channel
//   cfg_div    in   [WIDTH]  new divisor (period in inclk cycles, >= 2)
//   cfg_ready  out  write can be accepted this cycle
//   cfg_err    out  1-cycle pulse after a rejected (invalid) write
//   newclk     out  [NCH]    divided clocks, registered
//   tick       out  [NCH]    1-cycle strobe at each newclk rising edge
//
// Config handshake: a write transfers on a rising edge where
// cfg_valid && cfg_ready. cfg_ready depends only on cfg_ch and registered
// state (never on cfg_valid). It is low only while the addressed channel
// already holds a pending divisor. Writes to a nonexistent channel or with
// cfg_div < 2 still transfer, but are discarded and raise cfg_err.

module clkdiv_multi #(
    parameter int NCH         = 4,
    parameter int WIDTH       = 32,
    parameter int DEFAULT_DIV = 200000,
    parameter int CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             inclk,
    input  logic             reset,
    input  logic [NCH-1:0]   enable,
    input  logic             sync,
    input  logic             cfg_valid,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [NCH-1:0]   newclk,
    output logic [NCH-1:0]   tick
);

    logic [NCH-1:0] pv_vec;    // pending-divisor flags, gathered from channels
    logic [NCH-1:0] ch_sel;    // one-hot decode of cfg_ch (all zero if out of range)
    logic [NCH-1:0] wr_hit;    // valid write accepted for this channel
    logic           accept;
    logic           div_ok;
    logic           bad_wr;

    // Decode loops over real channels only, so an out-of-range cfg_ch
    // naturally selects nothing and reads as ready.
    always_comb begin
        ch_sel    = '0;
        cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == CHW'(i)) begin
                ch_sel[i] = 1'b1;
                if (pv_vec[i]) begin
                    cfg_ready = 1'b0;
                end
            end
        end
    end

    assign accept = cfg_valid && cfg_ready;
    assign div_ok = (cfg_div >= WIDTH'(2));
    assign bad_wr = accept && !(div_ok && (|ch_sel));
    assign wr_hit = (accept && div_ok) ? ch_sel : '0;

    always_ff @(posedge inclk) begin
        if (reset) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= bad_wr;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] div_q;
        logic [WIDTH-1:0] pdiv_q;
        logic             pv_q;
        logic             run_q;
        logic             clk_q;
        logic             tick_q;

        logic             wrap;
        logic [WIDTH-1:0] cnt_n;
        logic [WIDTH-1:0] div_run;   // divisor governing cnt_n
        logic [WIDTH:0]   hi;        // one bit wider so div+1 cannot overflow

        always_comb begin
            wrap    = (cnt_q == div_q - WIDTH'(1));
            cnt_n   = wrap ? '0 : cnt_q + WIDTH'(1);
            // A pending divisor takes over exactly at the wrap, so the
            // new period's high phase already uses the new threshold.
            div_run = (wrap && pv_q) ? pdiv_q : div_q;
            hi      = ({1'b0, div_run} + (WIDTH + 1)'(1)) >> 1;
        end

        always_ff @(posedge inclk) begin
            if (reset) begin
                cnt_q  <= '0;
                div_q  <= WIDTH'(DEFAULT_DIV);
                pdiv_q <= '0;
                pv_q   <= 1'b0;
                run_q  <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                if (!enable[g]) begin
                    cnt_q  <= '0;
                    run_q  <= 1'b0;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                    if (pv_q) begin
                        div_q <= pdiv_q;
                        pv_q  <= 1'b0;
                    end
                end else if (!run_q || sync) begin
                    cnt_q  <= '0;
                    run_q  <= 1'b1;
                    clk_q  <= 1'b1;
                    tick_q <= 1'b1;
                    if (pv_q) begin
                        div_q <= pdiv_q;
                        pv_q  <= 1'b0;
                    end
                end else begin
                    cnt_q  <= cnt_n;
                    clk_q  <= ({1'b0, cnt_n} < hi);
                    tick_q <= (cnt_n == '0);
                    if (wrap && pv_q) begin
                        div_q <= pdiv_q;
                        pv_q  <= 1'b0;
                    end
                end

                // wr_hit implies pv_q was 0, so this never collides with
                // a pending load above; it only ever targets an idle or
                // a live channel with nothing queued.
                if (wr_hit[g]) begin
                    if (!run_q && !enable[g]) begin
                        div_q <= cfg_div;
                    end else begin
                        pdiv_q <= cfg_div;
                        pv_q   <= 1'b1;
                    end
                end
            end
        end

        assign pv_vec[g] = pv_q;
        assign newclk[g] = clk_q;
        assign tick[g]   = tick_q;
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Testbench for clkdiv_multi: NCH=4, WIDTH=16, DEFAULT_DIV=10, CHW=3 so that
// an out-of-range channel number (5) can be presented on cfg_ch.
module tb_clkdiv_multi;

    localparam int NCH         = 4;
    localparam int WIDTH       = 16;
    localparam int DEFAULT_DIV = 10;
    localparam int CHW         = 3;
    localparam int NVEC        = 50;

    logic             inclk = 1'b0;
    logic             reset = 1'b1;
    logic [NCH-1:0]   enable = '0;
    logic             sync = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [CHW-1:0]   cfg_ch = '0;
    logic [WIDTH-1:0] cfg_div = '0;
    logic             cfg_ready;
    logic             cfg_err;
    logic [NCH-1:0]   newclk;
    logic [NCH-1:0]   tick;

    clkdiv_multi #(
        .NCH(NCH), .WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV), .CHW(CHW)
    ) dut (
        .inclk(inclk), .reset(reset), .enable(enable), .sync(sync),
        .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err),
        .newclk(newclk), .tick(tick)
    );

    // ---------------- clock ----------------
    always #5 inclk = ~inclk;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];   // {newclk, tick} per cycle

    typedef struct {
        logic [3:0]  en;
        logic        cv;
        logic [2:0]  ch;
        logic [15:0] dv;
        logic [3:0]  exp_clk;
        logic [3:0]  exp_tick;
        logic        exp_err;
    } vec_t;

    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_q(input string name);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: expected queue empty", name);
        end else begin
            e = exp_q.pop_front();
            check(name, {24'd0, newclk, tick}, {24'd0, e});
        end
    endtask

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge inclk);
        #1;
    endtask

    // Direct write to an idle channel (or any write where ready is expected).
    task automatic cfg_write(input int ch, input int dv);
        cfg_valid = 1'b1;
        cfg_ch    = CHW'(ch);
        cfg_div   = WIDTH'(dv);
        #1;
        check($sformatf("ready_wr_ch%0d", ch), {31'd0, cfg_ready}, 32'd1);
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        // ---------- stimulus table ----------
        // ch0 runs at the default divisor throughout; invalid writes at rows
        // 20/22/24 must not disturb ch1/ch2, which later start in phase with
        // ch0 and must show the same default 10-cycle pattern.
        for (int r = 0; r < NVEC; r++) begin
            logic c;
            logic t;
            c = ((r % 10) < 5);
            t = ((r % 10) == 0);
            vecs[r].en = (r < 30) ? 4'b0001 : (r < 40) ? 4'b0011 : 4'b0111;
            vecs[r].cv = 1'b0;
            vecs[r].ch = 3'd0;
            vecs[r].dv = 16'd0;
            vecs[r].exp_err = 1'b0;
            vecs[r].exp_clk  = {1'b0, (r >= 40) & c, (r >= 30) & c, c};
            vecs[r].exp_tick = {1'b0, (r >= 40) & t, (r >= 30) & t, t};
        end
        vecs[20].cv = 1'b1; vecs[20].ch = 3'd1; vecs[20].dv = 16'd1; vecs[20].exp_err = 1'b1;
        vecs[22].cv = 1'b1; vecs[22].ch = 3'd2; vecs[22].dv = 16'd0; vecs[22].exp_err = 1'b1;
        vecs[24].cv = 1'b1; vecs[24].ch = 3'd5; vecs[24].dv = 16'd7; vecs[24].exp_err = 1'b1;

        // ---------- reset ----------
        reset = 1'b1;
        repeat (3) step();
        check("rst_newclk", {28'd0, newclk}, 32'd0);
        check("rst_tick", {28'd0, tick}, 32'd0);
        check("rst_err", {31'd0, cfg_err}, 32'd0);
        check("rst_ready", {31'd0, cfg_ready}, 32'd1);

        // ---------- table-driven phase ----------
        reset = 1'b0;
        for (int r = 0; r < NVEC; r++) begin
            enable    = vecs[r].en;
            cfg_valid = vecs[r].cv;
            cfg_ch    = vecs[r].ch;
            cfg_div   = vecs[r].dv;
            step();
            check($sformatf("vec%0d_clk", r), {28'd0, newclk}, {28'd0, vecs[r].exp_clk});
            check($sformatf("vec%0d_tick", r), {28'd0, tick}, {28'd0, vecs[r].exp_tick});
            check($sformatf("vec%0d_err", r), {31'd0, cfg_err}, {31'd0, vecs[r].exp_err});
        end
        cfg_valid = 1'b0;

        // ---------- disable all ----------
        enable = 4'b0000;
        step();
        check("dis_all_clk", {28'd0, newclk}, 32'd0);
        check("dis_all_tick", {28'd0, tick}, 32'd0);

        // ---------- odd divisor 3, then 2, on ch1 ----------
        cfg_write(1, 3);
        enable = 4'b0010;
        for (int t = 0; t < 6; t++) begin
            step();
            check($sformatf("div3_clk_t%0d", t), {31'd0, newclk[1]}, {31'd0, (t % 3) < 2});
            check($sformatf("div3_tick_t%0d", t), {31'd0, tick[1]}, {31'd0, (t % 3) == 0});
        end
        enable = 4'b0000;
        step();
        cfg_write(1, 2);
        enable = 4'b0010;
        for (int t = 0; t < 4; t++) begin
            step();
            check($sformatf("div2_clk_t%0d", t), {31'd0, newclk[1]}, {31'd0, (t % 2) == 0});
            check($sformatf("div2_tick_t%0d", t), {31'd0, tick[1]}, {31'd0, (t % 2) == 0});
        end

        // ---------- live update on ch0 (div 10 -> 4 -> 6) ----------
        enable = 4'b0000;
        step();
        enable = 4'b0001;
        repeat (4) step();   // ch0 now at cnt=3
        begin
            logic [16:0] exp_clk_seq;
            logic [16:0] exp_tick_seq;
            // bit e-1 = value after edge E<e>
            exp_clk_seq  = 17'b1_0001_1100_1100_0001;
            exp_tick_seq = 17'b1_0000_0100_0100_0000;
            for (int e = 1; e <= 17; e++) begin
                if (e <= 8) begin
                    cfg_valid = 1'b1;
                    cfg_ch    = 3'd0;
                    cfg_div   = (e == 1) ? 16'd4 : 16'd6;
                    #1;
                    check($sformatf("live_ready_E%0d", e), {31'd0, cfg_ready},
                          {31'd0, (e == 1) || (e == 8)});
                end else begin
                    cfg_valid = 1'b0;
                end
                step();
                check($sformatf("live_clk_E%0d", e), {31'd0, newclk[0]}, {31'd0, exp_clk_seq[e-1]});
                check($sformatf("live_tick_E%0d", e), {31'd0, tick[0]}, {31'd0, exp_tick_seq[e-1]});
            end
            cfg_valid = 1'b0;
        end

        // ---------- sync: ch0 div 6, ch2 div 9 ----------
        enable = 4'b0000;
        step();
        cfg_write(0, 6);
        cfg_write(2, 9);
        enable = 4'b0101;
        for (int t = 0; t < 4; t++) begin
            step();
            check($sformatf("pre_sync_ch0_t%0d", t), {31'd0, newclk[0]}, {31'd0, t < 3});
            check($sformatf("pre_sync_ch2_t%0d", t), {31'd0, newclk[2]}, {31'd0, t < 5});
        end
        for (int t = 0; t <= 18; t++) begin
            logic [3:0] c;
            logic [3:0] k;
            c = {1'b0, (t % 9) < 5, 1'b0, (t % 6) < 3};
            k = {1'b0, (t % 9) == 0, 1'b0, (t % 6) == 0};
            exp_q.push_back({c, k});
        end
        sync = 1'b1;
        step();
        sync = 1'b0;
        check_q("sync_t0");
        for (int t = 1; t <= 18; t++) begin
            step();
            check_q($sformatf("sync_t%0d", t));
        end

        // ---------- disable mid-high with pending write on ch0 ----------
        cfg_valid = 1'b1;
        cfg_ch    = 3'd0;
        cfg_div   = 16'd8;
        #1;
        check("pend_ready_before", {31'd0, cfg_ready}, 32'd1);
        step();                      // ch0 cnt=1, high, pending div=8
        cfg_valid = 1'b0;
        check("pend_ready_after", {31'd0, cfg_ready}, 32'd0);
        check("pend_clk_high", {31'd0, newclk[0]}, 32'd1);
        enable = 4'b0100;
        step();
        check("dis_ch0_clk", {31'd0, newclk[0]}, 32'd0);
        check("dis_ch0_tick", {31'd0, tick[0]}, 32'd0);
        check("dis_ch2_runs", {31'd0, newclk[2]}, 32'd1);
        check("dis_pend_applied_ready", {31'd0, cfg_ready}, 32'd1);
        enable = 4'b0101;
        for (int t = 0; t < 9; t++) begin
            step();
            check($sformatf("div8_clk_t%0d", t), {31'd0, newclk[0]}, {31'd0, (t % 8) < 4});
            check($sformatf("div8_tick_t%0d", t), {31'd0, tick[0]}, {31'd0, (t % 8) == 0});
        end

        // ---------- reset mid-period with pending write on ch2 ----------
        cfg_valid = 1'b1;
        cfg_ch    = 3'd2;
        cfg_div   = 16'd3;
        step();
        cfg_valid = 1'b0;
        check("rst_pend_ready", {31'd0, cfg_ready}, 32'd0);
        // invalid write on the reset edge: reset wins, no cfg_err
        reset     = 1'b1;
        enable    = 4'b0000;
        cfg_valid = 1'b1;
        cfg_ch    = 3'd1;
        cfg_div   = 16'd1;
        step();
        cfg_valid = 1'b0;
        check("mid_rst_clk", {28'd0, newclk}, 32'd0);
        check("mid_rst_tick", {28'd0, tick}, 32'd0);
        check("mid_rst_err", {31'd0, cfg_err}, 32'd0);
        cfg_ch = 3'd2;
        #1;
        check("mid_rst_pend_lost", {31'd0, cfg_ready}, 32'd1);
        reset  = 1'b0;
        enable = 4'b0100;
        for (int t = 0; t < 11; t++) begin
            step();
            check($sformatf("post_rst_clk_t%0d", t), {28'd0, newclk},
                  {29'd0, (t % 10) < 5, 2'b00});
            check($sformatf("post_rst_tick_t%0d", t), {28'd0, tick},
                  {29'd0, (t % 10) == 0, 2'b00});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clkdiv_multi.md
# clkdiv_multi

Parametrised, multi-channel successor to the single fixed-ratio clock divider. Each of NCH channels derives a square wave from `inclk`, with a per-channel divisor that is programmable at run time. Each channel also provides a per-channel enable, a one-cycle tick strobe, and glitch-free divisor updates applied at period boundaries. A global `sync` realigns every running channel's phase. It sits between the system clock and the measurement counters and peripherals that need slow enables or slow clocks.

## Interface
- NCH, 4: number of independent channels (1..16).
- WIDTH, 32: divisor and counter width in bits.
- DEFAULT_DIV, 200000: divisor loaded into every channel at reset; must satisfy 2 <= DEFAULT_DIV < 2^WIDTH.
- CHW, $clog2(NCH) (minimum 1): channel select width.

- inclk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  NCH  per-channel run enable.
- sync  in  1  single-cycle pulse that restarts all running channels at phase 0.
- cfg_valid  in  1  divisor write request.
- cfg_ch  in  CHW  target channel.
- cfg_div  in  WIDTH  new divisor, given as the period in `inclk` cycles.
- cfg_ready  out  1  write can be accepted this cycle.
- cfg_err  out  1  one-cycle pulse when a rejected write is accepted.
- newclk  out  NCH  divided clocks, registered.
- tick  out  NCH  one-cycle strobe at each rising edge of `newclk[i]`, registered.

## Operation
- Per channel state:
  - `cnt[WIDTH]` and `div[WIDTH]`.
  - Pending divisor `pdiv[WIDTH]` plus pending flag `pv`.
  - `run` flag.
- Derived threshold: hi = (div+1)>>1.
  - `newclk` is high for hi cycles and low for div-hi cycles per period.
  - Even divisors give 50% duty.
  - Odd divisors give high for one cycle longer than low; e.g. div=3 gives 2 high, 1 low.
- Per-channel update priority at each edge, highest first:
  1. **reset:** cnt=0, div=DEFAULT_DIV, pv=0, run=0, newclk=0, tick=0, cfg_err=0.
  2. **enable[i]=0:** cnt<=0, run<=0, newclk<=0, tick<=0. If pv=1, div<=pdiv and pv<=0.
  3. **Start** (enable[i]=1, run=0), or **sync=1 while running:**
     - cnt<=0, run<=1, newclk<=1, tick<=1.
     - If pv=1, div<=pdiv and pv<=0.
  4. **Running:**
     - cnt_n = (cnt==div-1) ? 0 : cnt+1.
     - At wrap with pv=1, div<=pdiv and pv<=0; the new divisor governs the period that starts at this wrap.
     - newclk<=(cnt_n < hi of the divisor in force for cnt_n); tick<=(cnt_n==0).
- Config handshake:
  - cfg_ready = !pv[cfg_ch] when cfg_ch<NCH, else 1. It is combinational from registered state and is 1 after reset.
  - A write is accepted on an edge where cfg_valid&&cfg_ready.
  - **Invalid write** (cfg_div<2 or cfg_ch>=NCH): accepted and discarded, with no state change; cfg_err=1 in the following cycle only.
  - **Valid write, channel not running and enable[ch]=0 at that edge:** div<=cfg_div directly.
  - **Valid write otherwise:** pdiv<=cfg_div, pv<=1.
  - A valid write accepted on the same edge as a wrap or sync goes to pending; it does not apply at that edge.
- Channels are fully independent, except that they share `sync` and the config port.

## Timing
- Enable latency: enable[i] rises before edge k, so newclk[i]=1 and tick[i]=1 after edge k.
- Steady state: tick[i] asserts every div cycles exactly, and period error is zero.
- Disable: enable[i] falls before edge k, so newclk[i]=0 after edge k with no runt high pulse beyond edge k.
- Sync: visible at edge k+1 relative to the pulse at edge k. All running channels show tick=1 in the same cycle.
- Divisor change: the old period always completes. The first period at the new divisor begins with the next tick, and no intermediate-length period occurs.
- cnt never reaches div; if div shrinks via pending, the load happens only at wrap, so cnt is always < div.
- Reset mid-period: newclk and tick are 0 from the next cycle; a pending write is lost.

## Test plan
- **Reset:** reset, then NCH=4, DEFAULT_DIV=10, enable=4'b0001.
  - newclk[0] shows period 10, 5 high and 5 low; tick[0] appears every 10 cycles.
  - First tick occurs one cycle after enable rises; other channels stay 0.
- **Odd divisor:** with the channel idle, write div=3 to ch1, then enable it. Pattern is 1,1,0 repeating; div=2 gives 1,0.
- **Live update:** ch0 running at div=10; write div=4 mid-period.
  - The current 10-cycle period completes, then 4-cycle periods follow.
  - cfg_ready for ch0 is 0 until the wrap; a second write is stalled and then accepted.
- **Invalid writes:** div=1 and div=0 each give one cfg_err pulse with no divisor change. cfg_ch=5 with NCH=4 behaves the same way.
- **Sync:** ch0 div=6 and ch2 div=9, both running; pulse sync. Both tick on the same cycle, one cycle after sync, and periods are unchanged thereafter.
- **Disable and reset mid-operation:** drop enable mid-high, then drop reset mid-period with a pending write.
  - newclk goes to 0 the next cycle.
  - Pending is applied on disable, or discarded on reset.
  - After reset, div=DEFAULT_DIV.
